// File: rtl/tm1638_serial_driver.sv
// Continuous TM1638 refresh driver: one frame = mode byte, 16-byte display write, brightness byte.
// Define TM1638_HEX_FONT_EN to render digit codes 10-15 as A b C d E F instead of blank.
`timescale 1ns/1ps
module tm1638_serial_driver #(
   parameter int CLK_DIV   = 25,
   parameter int GAP_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] digits,
   input  logic [7:0]  blank,
   input  logic [7:0]  leds,
   input  logic [2:0]  brightness,
   output logic        tm_clk,
   output logic        tm_stb,
   output logic        tm_dio,
   output logic        frame_done
);

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = $clog2(GAP_TICKS + 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_TICKS - 1);

   typedef enum logic [1:0] {S_START, S_SHIFT, S_STOP, S_GAP} state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    bit_cnt;
   logic [4:0]    byte_idx;
   logic [4:0]    last_idx;
   logic [1:0]    txn;
   logic [31:0]   snap_digits;
   logic [7:0]    snap_blank;
   logic [7:0]    snap_leds;
   logic [2:0]    snap_bright;
   logic [7:0]    cur_byte;
   logic [7:0]    nxt_byte;

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
`ifdef TM1638_HEX_FONT_EN
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         4'hF: seg = 8'h71;
`endif
         default: seg = 8'h00;
      endcase
   endfunction

   // Byte idx of transaction t; in T1 idx 0 is the address command, idx k is display address k-1.
   function automatic logic [7:0] byte_at(input logic [1:0] t, input logic [4:0] idx,
                                          input logic [31:0] dg, input logic [7:0] bl,
                                          input logic [7:0] ld, input logic [2:0] br);
      logic [3:0] addr;
      logic [2:0] i;
      addr    = 4'(idx - 5'd1);
      i       = addr[3:1];
      byte_at = 8'h00;
      case (t)
         2'd0: byte_at = 8'h40;
         2'd1: begin
            if (idx == 5'd0)
               byte_at = 8'hC0;
            else if (!addr[0])
               byte_at = bl[i] ? 8'h00 : seg(dg[{i, 2'b00} +: 4]);
            else
               byte_at = {7'b0, ld[i]};
         end
         default: byte_at = {5'b10001, br};
      endcase
   endfunction

   assign tick     = (tick_cnt == TICK_MAX);
   assign last_idx = (txn == 2'd1) ? 5'd16 : 5'd0;
   assign cur_byte = byte_at(txn, byte_idx, snap_digits, snap_blank, snap_leds, snap_bright);
   assign nxt_byte = byte_at(txn, byte_idx + 5'd1, snap_digits, snap_blank, snap_leds, snap_bright);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   // Reset parks the bus in the gap after T2 so the first frame starts cleanly after GAP_TICKS ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_GAP;
         txn         <= 2'd2;
         gap_cnt     <= '0;
         bit_cnt     <= '0;
         byte_idx    <= '0;
         tm_clk      <= 1'b1;
         tm_stb      <= 1'b1;
         tm_dio      <= 1'b1;
         frame_done  <= 1'b0;
         snap_digits <= '0;
         snap_blank  <= '0;
         snap_leds   <= '0;
         snap_bright <= '0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            case (state)
               S_GAP: begin
                  if (gap_cnt == GAP_MAX) begin
                     state    <= S_START;
                     tm_stb   <= 1'b0;
                     byte_idx <= '0;
                     if (txn == 2'd2) begin
                        txn         <= 2'd0;
                        frame_done  <= 1'b1;
                        snap_digits <= digits;
                        snap_blank  <= blank;
                        snap_leds   <= leds;
                        snap_bright <= brightness;
                     end else begin
                        txn <= txn + 2'd1;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               S_START: begin
                  state   <= S_SHIFT;
                  bit_cnt <= '0;
                  tm_clk  <= 1'b0;
                  tm_dio  <= cur_byte[0];
               end
               S_SHIFT: begin
                  if (!bit_cnt[0]) begin
                     tm_clk  <= 1'b1;
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (bit_cnt == 4'd15) begin
                     if (byte_idx == last_idx) begin
                        state <= S_STOP;
                     end else begin
                        byte_idx <= byte_idx + 5'd1;
                        bit_cnt  <= '0;
                        tm_clk   <= 1'b0;
                        tm_dio   <= nxt_byte[0];
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     tm_clk  <= 1'b0;
                     tm_dio  <= cur_byte[bit_cnt[3:1] + 3'd1];
                  end
               end
               default: begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                  tm_stb  <= 1'b1;
                  tm_dio  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tm1638_serial_driver.sv
// Directed bench for tm1638_serial_driver: decodes the serial bus and checks frames, snapshot and reset.
`timescale 1ns/1ps
module tb_tm1638_serial_driver;

   localparam int CLK_DIV    = 2;
   localparam int GAP_TICKS  = 4;
   localparam int FRAME_CLKS = (6 + 304 + 3 * GAP_TICKS) * CLK_DIV;
   localparam int GAP_CLKS   = GAP_TICKS * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] digits = '0;
   logic [7:0]  blank = '0;
   logic [7:0]  leds = '0;
   logic [2:0]  brightness = '0;
   logic        tm_clk, tm_stb, tm_dio, frame_done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_done = 0;

   logic [7:0] byte_q[$];
   int         len_q[$];
   int         gap_q[$];

   logic [7:0] a_lit [19] = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h06, 8'h00, 8'h5B, 8'h01, 8'h4F, 8'h00,
                              8'h66, 8'h00, 8'h6D, 8'h01, 8'h7D, 8'h00, 8'h07, 8'h01, 8'h8D};

   tm1638_serial_driver #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .leds(leds),
      .brightness(brightness), .tm_clk(tm_clk), .tm_stb(tm_stb), .tm_dio(tm_dio),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus decoder: shifts DIO in on each tm_clk rise while STB is low, LSB first.
   initial begin
      logic       prev_clk = 1'b1;
      logic       prev_stb = 1'b1;
      logic [7:0] shreg = '0;
      int         nbits = 0;
      int         nbytes = 0;
      int         hi_cnt = 0;
      forever begin
         @(negedge clk);
         if (tm_stb === 1'b0) begin
            if (prev_stb === 1'b1) begin
               gap_q.push_back(hi_cnt);
               hi_cnt = 0;
            end
            if (tm_clk === 1'b1 && prev_clk === 1'b0) begin
               shreg = {tm_dio, shreg[7:1]};
               nbits++;
               if (nbits == 8) begin
                  byte_q.push_back(shreg);
                  nbits = 0;
                  nbytes++;
               end
            end
         end else begin
            if (prev_stb === 1'b0) len_q.push_back(nbytes);
            nbytes = 0;
            nbits  = 0;
            hi_cnt++;
         end
         prev_clk = tm_clk;
         prev_stb = tm_stb;
      end
   end

   function automatic logic [7:0] seg_ref(input logic [3:0] d);
      case (d)
         4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
         4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
         4'h8: return 8'h7F;  4'h9: return 8'h6F;
`ifdef TM1638_HEX_FONT_EN
         4'hA: return 8'h77;  4'hB: return 8'h7C;  4'hC: return 8'h39;
         4'hD: return 8'h5E;  4'hE: return 8'h79;  4'hF: return 8'h71;
`endif
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] exp_byte(input int k, input logic [31:0] dg, input logic [7:0] bl,
                                           input logic [7:0] ld, input logic [2:0] br);
      int addr;
      int i;
      if (k == 0) return 8'h40;
      if (k == 1) return 8'hC0;
      if (k == 18) return 8'h88 | {5'b0, br};
      addr = k - 2;
      i    = addr / 2;
      if (addr % 2 == 0) return bl[i] ? 8'h00 : seg_ref(dg[4*i +: 4]);
      return {7'b0, ld[i]};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] dg, input logic [7:0] bl,
                                 input logic [7:0] ld, input logic [2:0] br);
      digits     = dg;
      blank      = bl;
      leds       = ld;
      brightness = br;
   endtask

   task automatic clear_queues();
      byte_q.delete();
      len_q.delete();
      gap_q.delete();
   endtask

   task automatic wait_stb_fall(output int n);
      n = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (tm_stb === 1'b0) begin
            n = k;
            break;
         end
      end
   endtask

   // Waits for the end-of-frame pulse and checks the frame period against the previous one.
   task automatic wait_frame(input string tag);
      bit found = 0;
      for (int k = 0; k < FRAME_CLKS + 100; k++) begin
         @(posedge clk);
         #1;
         if (frame_done === 1'b1) begin
            found = 1;
            break;
         end
      end
      check_output({tag, ".done_seen"}, 32'(found), 32'd1);
      check_output({tag, ".period"}, 32'(cyc - last_done), 32'(FRAME_CLKS));
      last_done = cyc;
   endtask

   task automatic check_frame(input string tag, input logic [31:0] dg, input logic [7:0] bl,
                              input logic [7:0] ld, input logic [2:0] br,
                              input bit use_lit, input bit chk_gaps);
      logic [7:0] got;
      logic [7:0] exp;
      check_output({tag, ".nbytes"}, 32'(byte_q.size()), 32'd19);
      for (int k = 0; k < 19; k++) begin
         got = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
         exp = use_lit ? a_lit[k] : exp_byte(k, dg, bl, ld, br);
         check_output($sformatf("%s.byte[%0d]", tag, k), {24'd0, got}, {24'd0, exp});
      end
      check_output({tag, ".ntxn"}, 32'(len_q.size()), 32'd3);
      for (int t = 0; t < 3; t++)
         check_output($sformatf("%s.txn_len[%0d]", tag, t),
                      (t < len_q.size()) ? 32'(len_q[t]) : 32'hFFFF_FFFF, (t == 1) ? 32'd17 : 32'd1);
      if (chk_gaps) begin
         check_output({tag, ".ngaps"}, 32'(gap_q.size()), 32'd3);
         for (int t = 0; t < 3; t++)
            check_output($sformatf("%s.gap[%0d]", tag, t),
                         (t < gap_q.size()) ? 32'(gap_q[t]) : 32'hFFFF_FFFF, 32'(GAP_CLKS));
      end
   endtask

   task automatic check_pulse(input string tag);
      @(posedge clk);
      #1;
      check_output({tag, ".pulse_width"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      int n;
      apply_stimulus(32'h7654_3210, 8'h00, 8'hA5, 3'd5);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset.tm_clk", {31'd0, tm_clk}, 32'd1);
      check_output("reset.tm_stb", {31'd0, tm_stb}, 32'd1);
      check_output("reset.tm_dio", {31'd0, tm_dio}, 32'd1);
      check_output("reset.frame_done", {31'd0, frame_done}, 32'd0);

      clear_queues();
      @(negedge clk);
      rst_n = 1'b1;
      wait_stb_fall(n);
      check_output("reset.first_stb_fall_clks", 32'(n), 32'(GAP_CLKS));
      last_done = cyc;
      clear_queues();
      apply_stimulus(32'hFEDC_BA98, 8'h81, 8'h3C, 3'd7);

      wait_frame("frameA");
      check_frame("frameA", 32'h7654_3210, 8'h00, 8'hA5, 3'd5, 1'b1, 1'b0);
      clear_queues();
      check_pulse("frameA");
      apply_stimulus(32'h1111_1111, 8'h00, 8'h00, 3'd0);

      wait_frame("frameB");
      check_frame("frameB", 32'hFEDC_BA98, 8'h81, 8'h3C, 3'd7, 1'b0, 1'b1);
      clear_queues();
      check_pulse("frameB");

      repeat (100) @(posedge clk);
      #1;
      apply_stimulus(32'h2222_2222, 8'h00, 8'h00, 3'd0);
      wait_frame("frameC");
      check_frame("frameC", 32'h1111_1111, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
      clear_queues();
      check_pulse("frameC");

      wait_frame("frameD");
      check_frame("frameD", 32'h2222_2222, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
      clear_queues();
      check_pulse("frameD");

      repeat (219) @(posedge clk);
      #1;
      check_output("midbyte.stb_low_before_reset", {31'd0, tm_stb}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_output("midbyte.tm_clk", {31'd0, tm_clk}, 32'd1);
      check_output("midbyte.tm_stb", {31'd0, tm_stb}, 32'd1);
      check_output("midbyte.tm_dio", {31'd0, tm_dio}, 32'd1);
      check_output("midbyte.frame_done", {31'd0, frame_done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      clear_queues();
      @(negedge clk);
      rst_n = 1'b1;
      wait_stb_fall(n);
      check_output("restart.stb_fall_clks", 32'(n), 32'(GAP_CLKS));
      for (int k = 0; k < 100 && byte_q.size() == 0; k++) @(posedge clk);
      #1;
      check_output("restart.byte_seen", 32'(byte_q.size() != 0), 32'd1);
      check_output("restart.first_byte", (byte_q.size() != 0) ? {24'd0, byte_q[0]} : 32'hFFFF_FFFF,
                   32'h40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
